// File: rtl/rl_lj_force_accumulator.sv
`timescale 1ns/1ps
// Sums the per-pair IEEE-754 LJ forces of each reference particle in signed fixed point
// and issues one force-cache write per reference.
module rl_lj_force_accumulator #(
  parameter int DATA_WIDTH              = 32,
  parameter int REF_PARTICLE_NUM        = 100,
  parameter int REF_RAM_ADDR_WIDTH      = 7,
  parameter int NEIGHBOR_PARTICLE_NUM   = 100,
  parameter int NEIGHBOR_RAM_ADDR_WIDTH = 7,
  parameter int ACC_WIDTH               = 48,
  parameter int FRAC_BITS               = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          force_valid,
  input  logic [DATA_WIDTH-1:0]         force_x,
  input  logic [DATA_WIDTH-1:0]         force_y,
  input  logic [DATA_WIDTH-1:0]         force_z,
  input  logic                          pipeline_done,
  output logic [ACC_WIDTH-1:0]          acc_x,
  output logic [ACC_WIDTH-1:0]          acc_y,
  output logic [ACC_WIDTH-1:0]          acc_z,
  output logic [REF_RAM_ADDR_WIDTH-1:0] acc_addr,
  output logic                          acc_wren,
  output logic                          overflow,
  output logic                          count_error,
  output logic                          done
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;

  localparam logic [ACC_WIDTH-1:0] MAX_POS = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] MAX_NEG = {1'b1, {(ACC_WIDTH-2){1'b0}}, 1'b1};
  localparam logic signed [ACC_WIDTH:0] SUM_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SUM_MIN = {2'b11, {(ACC_WIDTH-2){1'b0}}, 1'b1};
  localparam logic [NEIGHBOR_RAM_ADDR_WIDTH-1:0] NBR_LAST =
    NEIGHBOR_RAM_ADDR_WIDTH'(NEIGHBOR_PARTICLE_NUM - 1);
  localparam logic [REF_RAM_ADDR_WIDTH-1:0] REF_LAST =
    REF_RAM_ADDR_WIDTH'(REF_PARTICLE_NUM - 1);

  // Returns {saturated, value}: float truncated toward zero into the fixed-point format.
  function automatic logic [ACC_WIDTH:0] to_fixed(input logic [DATA_WIDTH-1:0] f);
    logic [7:0]           e;
    logic [23:0]          mant;
    logic [ACC_WIDTH-1:0] mag;
    logic                 sat;
    int                   sh;
    e    = f[30:23];
    mant = {1'b1, f[22:0]};
    mag  = '0;
    sat  = 1'b0;
    sh   = int'({24'd0, e}) - 32'sd150 + FRAC_BITS;
    if (e == 8'd0) begin
      mag = '0;
    end else if (e == 8'hFF || sh >= ACC_WIDTH - 32'sd24) begin
      sat = 1'b1;
    end else if (sh >= 32'sd0) begin
      mag = {{(ACC_WIDTH-24){1'b0}}, mant} << sh;
    end else if (sh > -32'sd24) begin
      mag = {{(ACC_WIDTH-24){1'b0}}, mant >> (-sh)};
    end else begin
      mag = '0;
    end
    if (sat) begin
      mag = MAX_POS;
    end else begin
      mag = mag;
    end
    return {sat, (f[31] ? -mag : mag)};
  endfunction

  // Returns {saturated, sum} clamped symmetrically to [-MAX, +MAX].
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                 input logic [ACC_WIDTH-1:0] b);
    logic signed [ACC_WIDTH:0] s;
    s = $signed({a[ACC_WIDTH-1], a}) + $signed({b[ACC_WIDTH-1], b});
    if (s > SUM_MAX) begin
      return {1'b1, MAX_POS};
    end else if (s < SUM_MIN) begin
      return {1'b1, MAX_NEG};
    end else begin
      return {1'b0, s[ACC_WIDTH-1:0]};
    end
  endfunction

  state_t                             state_r;
  logic [NEIGHBOR_RAM_ADDR_WIDTH-1:0] nbr_cnt_r;
  logic [REF_RAM_ADDR_WIDTH-1:0]      ref_cnt_r;
  logic                               all_counted_r;
  logic                               early_r;
  logic                               s1_valid_r, s1_first_r, s1_last_r, s1_ovf_r;
  logic [REF_RAM_ADDR_WIDTH-1:0]      s1_ref_r;
  logic [ACC_WIDTH-1:0]               s1_x_r, s1_y_r, s1_z_r;
  logic [ACC_WIDTH-1:0]               acc_x_r, acc_y_r, acc_z_r;
  logic [REF_RAM_ADDR_WIDTH-1:0]      acc_addr_r;
  logic                               acc_wren_r, overflow_r, count_error_r, done_r;
  logic [ACC_WIDTH:0]                 conv_x_s, conv_y_s, conv_z_s;
  logic [ACC_WIDTH:0]                 next_x_s, next_y_s, next_z_s;
  logic                               early_done_s;

  // Stage-1 conversion, stage-2 load/add selection and early-termination detect.
  always_comb begin
    conv_x_s     = to_fixed(force_x);
    conv_y_s     = to_fixed(force_y);
    conv_z_s     = to_fixed(force_z);
    early_done_s = (state_r == ACCUM) && pipeline_done && !all_counted_r;
    if (s1_first_r) begin
      next_x_s = {1'b0, s1_x_r};
      next_y_s = {1'b0, s1_y_r};
      next_z_s = {1'b0, s1_z_r};
    end else begin
      next_x_s = sat_add(acc_x_r, s1_x_r);
      next_y_s = sat_add(acc_y_r, s1_y_r);
      next_z_s = sat_add(acc_z_r, s1_z_r);
    end
  end

  // Run control FSM, pair counters and the two-stage convert/accumulate pipeline.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      state_r       <= rst ? IDLE : ACCUM;
      nbr_cnt_r     <= '0;
      ref_cnt_r     <= '0;
      all_counted_r <= 1'b0;
      early_r       <= 1'b0;
      s1_valid_r    <= 1'b0;
      s1_first_r    <= 1'b0;
      s1_last_r     <= 1'b0;
      s1_ovf_r      <= 1'b0;
      s1_ref_r      <= '0;
      s1_x_r        <= '0;
      s1_y_r        <= '0;
      s1_z_r        <= '0;
      acc_x_r       <= '0;
      acc_y_r       <= '0;
      acc_z_r       <= '0;
      acc_addr_r    <= '0;
      acc_wren_r    <= 1'b0;
      overflow_r    <= 1'b0;
      count_error_r <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      acc_wren_r <= 1'b0;
      done_r     <= 1'b0;
      s1_valid_r <= 1'b0;
      case (state_r)
        IDLE: state_r <= IDLE;
        ACCUM: begin
          if (early_done_s) begin
            // The in-flight partial sum is discarded, never written.
            count_error_r <= 1'b1;
            early_r       <= 1'b1;
            done_r        <= 1'b1;
            acc_x_r       <= '0;
            acc_y_r       <= '0;
            acc_z_r       <= '0;
            state_r       <= DONE;
          end else begin
            if (force_valid && !all_counted_r) begin
              s1_valid_r <= 1'b1;
              s1_first_r <= (nbr_cnt_r == '0);
              s1_last_r  <= (nbr_cnt_r == NBR_LAST);
              s1_ref_r   <= ref_cnt_r;
              s1_x_r     <= conv_x_s[ACC_WIDTH-1:0];
              s1_y_r     <= conv_y_s[ACC_WIDTH-1:0];
              s1_z_r     <= conv_z_s[ACC_WIDTH-1:0];
              s1_ovf_r   <= conv_x_s[ACC_WIDTH] | conv_y_s[ACC_WIDTH] | conv_z_s[ACC_WIDTH];
              if (nbr_cnt_r == NBR_LAST) begin
                nbr_cnt_r     <= '0;
                ref_cnt_r     <= ref_cnt_r + 1'b1;
                all_counted_r <= (ref_cnt_r == REF_LAST);
              end else begin
                nbr_cnt_r <= nbr_cnt_r + 1'b1;
              end
            end
            if (s1_valid_r) begin
              acc_x_r    <= next_x_s[ACC_WIDTH-1:0];
              acc_y_r    <= next_y_s[ACC_WIDTH-1:0];
              acc_z_r    <= next_z_s[ACC_WIDTH-1:0];
              overflow_r <= overflow_r | s1_ovf_r | next_x_s[ACC_WIDTH]
                            | next_y_s[ACC_WIDTH] | next_z_s[ACC_WIDTH];
              acc_addr_r <= s1_ref_r;
              acc_wren_r <= s1_last_r;
              if (s1_last_r && (s1_ref_r == REF_LAST)) begin
                state_r <= DONE;
              end
            end
          end
        end
        DONE: begin
          // The early path already pulsed done on entry.
          done_r  <= !early_r;
          early_r <= 1'b0;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign acc_x       = acc_x_r;
  assign acc_y       = acc_y_r;
  assign acc_z       = acc_z_r;
  assign acc_addr    = acc_addr_r;
  assign acc_wren    = acc_wren_r;
  assign overflow    = overflow_r;
  assign count_error = count_error_r;
  assign done        = done_r;

endmodule

// File: tb/tb_rl_lj_force_accumulator.sv
`timescale 1ns/1ps
// Randomized bench for rl_lj_force_accumulator; expected sums come from a real-arithmetic
// model of the float-to-fixed rules with symmetric saturation.
module tb_rl_lj_force_accumulator;

  localparam int NREF = 2;
  localparam int NBR  = 3;
  localparam int NP   = NREF * NBR;
  localparam longint MAXV = (64'sd1 <<< 47) - 64'sd1;

  typedef struct { int cyc; int addr; logic [47:0] x; logic [47:0] y; logic [47:0] z; } wr_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, force_valid = 1'b0, pipeline_done = 1'b0;
  logic [31:0] force_x = 32'd0, force_y = 32'd0, force_z = 32'd0;
  logic [47:0] acc_x, acc_y, acc_z;
  logic [6:0]  acc_addr;
  logic        acc_wren, overflow, count_error, done;

  int vectors = 0, miscompares = 0, cyc = 0, pd_cyc = 0;
  logic [31:0] fx[NP], fy[NP], fz[NP];
  int          dcyc[$];
  wr_t         wr_q[$];
  int          done_q[$];
  logic [47:0] accz_hist[256];
  logic        ovf_hist[256];
  logic [47:0] exp_x[NREF], exp_y[NREF], exp_z[NREF];
  logic [47:0] saved_x[NREF], saved_y[NREF], saved_z[NREF];
  bit          exp_ovf;

  rl_lj_force_accumulator #(.REF_PARTICLE_NUM(NREF), .NEIGHBOR_PARTICLE_NUM(NBR)) dut (
    .clk(clk), .rst(rst), .start(start), .force_valid(force_valid),
    .force_x(force_x), .force_y(force_y), .force_z(force_z), .pipeline_done(pipeline_done),
    .acc_x(acc_x), .acc_y(acc_y), .acc_z(acc_z), .acc_addr(acc_addr), .acc_wren(acc_wren),
    .overflow(overflow), .count_error(count_error), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    accz_hist[cyc[7:0]] <= acc_z;
    ovf_hist[cyc[7:0]]  <= overflow;
    if (acc_wren) wr_q.push_back(wr_t'{cyc, int'(acc_addr), acc_x, acc_y, acc_z});
    if (done) done_q.push_back(cyc);
  end

  function automatic longint conv_m(input logic [31:0] f, output bit o);
    int  e;
    real r;
    e = int'(f[30:23]);
    o = 1'b0;
    if (e == 0) return 64'sd0;
    r = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (e - 103));
    if (e == 255 || r > real'(MAXV)) begin
      o = 1'b1;
      return f[31] ? -MAXV : MAXV;
    end
    return f[31] ? -longint'($floor(r)) : longint'($floor(r));
  endfunction

  function automatic longint sat_add_m(input longint a, input longint b, output bit o);
    longint s;
    s = a + b;
    o = 1'b0;
    if (s > MAXV) begin o = 1'b1; s = MAXV; end
    else if (s < -MAXV) begin o = 1'b1; s = -MAXV; end
    return s;
  endfunction

  task automatic acc_step(inout longint s, input logic [31:0] f, input bit first);
    longint v;
    bit o;
    v = conv_m(f, o);
    exp_ovf |= o;
    if (first) s = v;
    else begin s = sat_add_m(s, v, o); exp_ovf |= o; end
  endtask

  task automatic model_run(input int npairs);
    longint sx, sy, sz;
    sx = 0; sy = 0; sz = 0; exp_ovf = 1'b0;
    for (int r = 0; r < npairs / NBR; r++) begin
      for (int n = 0; n < NBR; n++) begin
        acc_step(sx, fx[r*NBR+n], n == 0);
        acc_step(sy, fy[r*NBR+n], n == 0);
        acc_step(sz, fz[r*NBR+n], n == 0);
      end
      exp_x[r] = 48'(sx); exp_y[r] = 48'(sy); exp_z[r] = 48'(sz);
    end
  endtask

  function automatic logic [31:0] rand_float();
    logic [7:0] e;
    case ($urandom_range(7, 0))
      0: e = 8'd0;
      1: e = 8'($urandom_range(156, 144));
      default: e = 8'($urandom_range(140, 95));
    endcase
    return {1'($urandom_range(1, 0)), e, 23'($urandom)};
  endfunction

  task automatic fill_random();
    for (int i = 0; i < NP; i++) begin
      fx[i] = rand_float(); fy[i] = rand_float(); fz[i] = rand_float();
    end
  endtask

  // mode 0: plain run, 1: pipeline_done after the pairs, 2: rst alongside the last pair
  task automatic run_stream(input int npairs, input int max_gap, input int mode);
    wr_q.delete(); done_q.delete(); dcyc.delete();
    start = 1'b1; force_valid = 1'b1;
    force_x = $urandom; force_y = $urandom; force_z = $urandom;
    @(posedge clk); #1;
    start = 1'b0; force_valid = 1'b0;
    for (int i = 0; i < npairs; i++) begin
      if (max_gap > 0) repeat ($urandom_range(max_gap, 1)) begin @(posedge clk); #1; end
      force_valid = 1'b1; force_x = fx[i]; force_y = fy[i]; force_z = fz[i];
      if (mode == 2 && i == npairs - 1) rst = 1'b1;
      dcyc.push_back(cyc);
      @(posedge clk); #1;
      force_valid = 1'b0; rst = 1'b0;
    end
    if (mode == 1) begin
      pipeline_done = 1'b1; pd_cyc = cyc;
      @(posedge clk); #1;
      pipeline_done = 1'b0;
    end
    repeat (8) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({acc_x, acc_y, acc_z, acc_addr, acc_wren, overflow, count_error, done} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got %h, expected 0",
               {acc_x, acc_y, acc_z, acc_addr, acc_wren, overflow, count_error, done});
    end
    rst = 1'b0;
    force_valid = 1'b1; force_x = 32'h3F800000; force_y = 32'h40000000; force_z = 32'h3F800000;
    repeat (4) begin @(posedge clk); #1; end
    force_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    vectors++;
    if (wr_q.size() != 0 || acc_x !== 48'd0) begin
      miscompares++;
      $display("FAIL idle_ignores_valid: writes %0d acc_x %h, expected 0 writes and 0", wr_q.size(), acc_x);
    end
  endtask

  task automatic test_basic();
    fill_random();
    fx[0] = 32'h3F800000; fx[1] = 32'h3F800000; fx[2] = 32'hBF000000;
    run_stream(3, 0, 0);
    model_run(3);
    vectors++;
    if (wr_q.size() != 1) begin
      miscompares++; $display("FAIL basic_write_count: got %0d, expected 1", wr_q.size());
    end else begin
      vectors++;
      if (wr_q[0].addr != 0 || wr_q[0].cyc != dcyc[2] + 2) begin
        miscompares++;
        $display("FAIL basic_addr_timing: addr %0d cyc %0d, expected 0 cyc %0d", wr_q[0].addr, wr_q[0].cyc, dcyc[2] + 2);
      end
      vectors++;
      if (wr_q[0].x !== 48'h000001800000 || {wr_q[0].y, wr_q[0].z} !== {exp_y[0], exp_z[0]}) begin
        miscompares++;
        $display("FAIL basic_sum: got %h %h %h, expected %h %h %h", wr_q[0].x, wr_q[0].y, wr_q[0].z,
                 48'h000001800000, exp_y[0], exp_z[0]);
      end
    end
    vectors++;
    if (done_q.size() != 0) begin
      miscompares++; $display("FAIL basic_no_done: got %0d done pulses, expected 0", done_q.size());
    end
  endtask

  task automatic test_back_to_back();
    fill_random();
    for (int i = 3; i < 6; i++) fy[i] = 32'h40000000;
    run_stream(NP, 0, 0);
    model_run(NP);
    vectors++;
    if (wr_q.size() != 2) begin
      miscompares++; $display("FAIL b2b_write_count: got %0d, expected 2", wr_q.size());
    end else begin
      for (int k = 0; k < NREF; k++) begin
        vectors++;
        if (wr_q[k].addr != k || wr_q[k].cyc != dcyc[k*NBR+2] + 2) begin
          miscompares++;
          $display("FAIL b2b_addr_timing: addr %0d cyc %0d, expected %0d cyc %0d", wr_q[k].addr, wr_q[k].cyc, k, dcyc[k*NBR+2] + 2);
        end
        vectors++;
        if ({wr_q[k].x, wr_q[k].y, wr_q[k].z} !== {exp_x[k], exp_y[k], exp_z[k]}) begin
          miscompares++;
          $display("FAIL b2b_sum: ref %0d got %h %h %h, expected %h %h %h", k, wr_q[k].x, wr_q[k].y, wr_q[k].z,
                   exp_x[k], exp_y[k], exp_z[k]);
        end
        saved_x[k] = exp_x[k]; saved_y[k] = exp_y[k]; saved_z[k] = exp_z[k];
      end
      vectors++;
      if (wr_q[1].y !== 48'h000006000000) begin
        miscompares++; $display("FAIL b2b_ref1_y: got %h, expected %h", wr_q[1].y, 48'h000006000000);
      end
      vectors++;
      if (done_q.size() != 1 || done_q[0] != wr_q[1].cyc + 1) begin
        miscompares++;
        $display("FAIL b2b_done: got %0d pulses (first cyc %0d), expected 1 at cyc %0d", done_q.size(),
                 (done_q.size() > 0) ? done_q[0] : -1, wr_q[1].cyc + 1);
      end
    end
    vectors++;
    if (overflow !== exp_ovf || count_error !== 1'b0) begin
      miscompares++; $display("FAIL b2b_flags: ovf %b cerr %b, expected %b 0", overflow, count_error, exp_ovf);
    end
  endtask

  task automatic test_gapped();
    run_stream(NP, 3, 0);
    vectors++;
    if (wr_q.size() != 2) begin
      miscompares++; $display("FAIL gap_write_count: got %0d, expected 2", wr_q.size());
    end else begin
      for (int k = 0; k < NREF; k++) begin
        vectors++;
        if (wr_q[k].addr != k || wr_q[k].cyc != dcyc[k*NBR+2] + 2 ||
            {wr_q[k].x, wr_q[k].y, wr_q[k].z} !== {saved_x[k], saved_y[k], saved_z[k]}) begin
          miscompares++;
          $display("FAIL gap_write: ref %0d addr %0d cyc %0d sum %h %h %h, expected cyc %0d sum %h %h %h", k,
                   wr_q[k].addr, wr_q[k].cyc, wr_q[k].x, wr_q[k].y, wr_q[k].z, dcyc[k*NBR+2] + 2,
                   saved_x[k], saved_y[k], saved_z[k]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    fill_random();
    fz[0] = 32'h7F800000; fz[1] = 32'hFF7FFFFF;
    run_stream(NP, 0, 0);
    model_run(NP);
    vectors++;
    if (ovf_hist[8'(dcyc[0] + 1)] !== 1'b0 || ovf_hist[8'(dcyc[0] + 2)] !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_ovf_onset: got %b then %b, expected 0 then 1", ovf_hist[8'(dcyc[0] + 1)], ovf_hist[8'(dcyc[0] + 2)]);
    end
    vectors++;
    if (accz_hist[8'(dcyc[0] + 2)] !== 48'h7FFFFFFFFFFF) begin
      miscompares++; $display("FAIL sat_inf_load: got %h, expected 7fffffffffff", accz_hist[8'(dcyc[0] + 2)]);
    end
    vectors++;
    if (accz_hist[8'(dcyc[1] + 2)] !== 48'd0) begin
      miscompares++; $display("FAIL sat_no_wrap: got %h, expected 0", accz_hist[8'(dcyc[1] + 2)]);
    end
    vectors++;
    if (wr_q.size() != 2) begin
      miscompares++; $display("FAIL sat_write_count: got %0d, expected 2", wr_q.size());
    end else if ({wr_q[0].z, wr_q[1].z} !== {exp_z[0], exp_z[1]}) begin
      miscompares++; $display("FAIL sat_sums: got %h %h, expected %h %h", wr_q[0].z, wr_q[1].z, exp_z[0], exp_z[1]);
    end
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++; $display("FAIL sat_sticky: got %b, expected 1", overflow);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++; $display("FAIL sat_clear_on_start: got %b, expected 0", overflow);
    end
  endtask

  task automatic test_early_done();
    fill_random();
    run_stream(4, 0, 1);
    model_run(4);
    vectors++;
    if (wr_q.size() != 1) begin
      miscompares++; $display("FAIL early_write_count: got %0d, expected 1", wr_q.size());
    end else if (wr_q[0].addr != 0 || {wr_q[0].x, wr_q[0].y, wr_q[0].z} !== {exp_x[0], exp_y[0], exp_z[0]}) begin
      miscompares++;
      $display("FAIL early_write: addr %0d sum %h %h %h, expected 0 %h %h %h", wr_q[0].addr,
               wr_q[0].x, wr_q[0].y, wr_q[0].z, exp_x[0], exp_y[0], exp_z[0]);
    end
    vectors++;
    if (count_error !== 1'b1) begin
      miscompares++; $display("FAIL early_count_error: got %b, expected 1", count_error);
    end
    vectors++;
    if (done_q.size() != 1 || done_q[0] != pd_cyc + 1) begin
      miscompares++;
      $display("FAIL early_done: got %0d pulses (first cyc %0d), expected 1 at cyc %0d", done_q.size(),
               (done_q.size() > 0) ? done_q[0] : -1, pd_cyc + 1);
    end
  endtask

  task automatic test_reset_midrun();
    fill_random();
    run_stream(3, 0, 2);
    vectors++;
    if (wr_q.size() != 0 || done_q.size() != 0) begin
      miscompares++; $display("FAIL rst_no_write: got %0d writes %0d dones, expected 0 0", wr_q.size(), done_q.size());
    end
    vectors++;
    if ({acc_x, acc_y, acc_z, acc_addr, acc_wren, overflow, count_error, done} !== '0) begin
      miscompares++;
      $display("FAIL rst_outputs: got %h, expected 0", {acc_x, acc_y, acc_z, acc_addr, acc_wren, overflow, count_error, done});
    end
    fill_random();
    run_stream(NP, 2, 0);
    model_run(NP);
    vectors++;
    if (wr_q.size() != 2) begin
      miscompares++; $display("FAIL rst_rerun_count: got %0d, expected 2", wr_q.size());
    end else if ({wr_q[0].x, wr_q[0].y, wr_q[0].z, wr_q[1].x, wr_q[1].y, wr_q[1].z} !==
                 {exp_x[0], exp_y[0], exp_z[0], exp_x[1], exp_y[1], exp_z[1]}) begin
      miscompares++;
      $display("FAIL rst_rerun_sums: got %h %h %h %h %h %h, expected %h %h %h %h %h %h",
               wr_q[0].x, wr_q[0].y, wr_q[0].z, wr_q[1].x, wr_q[1].y, wr_q[1].z,
               exp_x[0], exp_y[0], exp_z[0], exp_x[1], exp_y[1], exp_z[1]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      fill_random();
      run_stream(NP, it % 3, 0);
      model_run(NP);
      vectors++;
      if (wr_q.size() != 2) begin
        miscompares++; $display("FAIL rand_write_count: run %0d got %0d, expected 2", it, wr_q.size());
      end else begin
        for (int k = 0; k < NREF; k++) begin
          vectors++;
          if (wr_q[k].addr != k || wr_q[k].cyc != dcyc[k*NBR+2] + 2 ||
              {wr_q[k].x, wr_q[k].y, wr_q[k].z} !== {exp_x[k], exp_y[k], exp_z[k]}) begin
            miscompares++;
            $display("FAIL rand_write: run %0d ref %0d addr %0d cyc %0d sum %h %h %h, expected cyc %0d sum %h %h %h",
                     it, k, wr_q[k].addr, wr_q[k].cyc, wr_q[k].x, wr_q[k].y, wr_q[k].z,
                     dcyc[k*NBR+2] + 2, exp_x[k], exp_y[k], exp_z[k]);
          end
        end
        vectors++;
        if (done_q.size() != 1 || done_q[0] != wr_q[1].cyc + 1) begin
          miscompares++; $display("FAIL rand_done: run %0d got %0d pulses, expected 1 at cyc %0d", it, done_q.size(), wr_q[1].cyc + 1);
        end
      end
      vectors++;
      if (overflow !== exp_ovf || count_error !== 1'b0) begin
        miscompares++; $display("FAIL rand_flags: run %0d ovf %b cerr %b, expected %b 0", it, overflow, count_error, exp_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_gapped();
    test_saturation();
    test_early_done();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
